// File: rtl/lz_pkg.sv
// Shared constants and state encoding for the leading-zero detect / denormalize pair.
package lz_pkg;

    localparam int LZ_WIDTH = 4;
    localparam int LZ_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } lz_state_t;

endpackage

// File: rtl/lz_shift_reg.sv
// Datapath register for lz_denorm: parallel load or logical shift right by one, zero-filled.
// Load wins over shift; reset clears the register.
module lz_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= {1'b0, r_data[WIDTH-1:1]};
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/lz_denorm.sv
// Sequential denormalizer: restores norm_in >> min(lz_in,WIDTH), one bit per clock; result valid
// min(lz,WIDTH) edges after accept, held in DONE until out_ready; no accept outside IDLE.
module lz_denorm
    import lz_pkg::*;
#(
    parameter int WIDTH = LZ_WIDTH,
    parameter int CNT_W = LZ_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] norm_in,
    input  logic [CNT_W-1:0] lz_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             norm_err
);

    localparam logic [CNT_W-1:0] W_MAX = CNT_W'(WIDTH);

    lz_state_t        r_state;
    lz_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_norm_err;
    logic             w_norm_err_nxt;
    logic             w_accept;
    logic             w_load;
    logic             w_shift;
    logic [CNT_W-1:0] w_lz_sat;
    logic             w_err_in;
    logic [WIDTH-1:0] w_shift_q;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_lz_sat = (lz_in > W_MAX) ? W_MAX : lz_in;
    // An unset MSB is only legitimate for the all-zero operand; an oversize count is always bad.
    assign w_err_in = (lz_in > W_MAX) || ((lz_in < W_MAX) && !norm_in[WIDTH-1]);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_norm_err_nxt = r_norm_err;
        w_load         = 1'b0;
        w_shift        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load         = 1'b1;
                    w_cnt_nxt      = w_lz_sat;
                    w_norm_err_nxt = w_err_in;
                    w_state_nxt    = (w_lz_sat == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                w_shift   = 1'b1;
                w_cnt_nxt = r_cnt - 1'b1;
                if (w_cnt_nxt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_norm_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_norm_err <= w_norm_err_nxt;
        end
    end

    lz_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (norm_in),
        .o_data  (w_shift_q)
    );

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign data_out  = w_shift_q;
    assign norm_err  = r_norm_err;

endmodule

// File: tb/tb_lz_denorm.sv
// Directed bench for lz_denorm: reset, latency, saturation, backpressure and lzd round trip.
module tb_lz_denorm;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] norm_in;
    logic [2:0] lz_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] data_out;
    logic       norm_err;

    int checks = 0;
    int errors = 0;

    lz_denorm #(
        .WIDTH (4),
        .CNT_W (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .norm_in   (norm_in),
        .lz_in     (lz_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .norm_err  (norm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leading-zero count of a 4-bit value (4 for zero), as the upstream lzd would produce.
    function automatic logic [2:0] ref_lzd(input logic [3:0] x);
        logic [2:0] n;
        n = 3'd4;
        for (int b = 0; b < 4; b++) begin
            if (x[b]) n = 3'(3 - b);
        end
        return n;
    endfunction

    // Accept one operand, measure edges to out_valid, check result, then drain.
    task automatic run_op(input string tag, input logic [3:0] n, input logic [2:0] lz,
                          input logic [3:0] exp_d, input logic exp_e, input int exp_lat);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        norm_in  = n;
        lz_in    = lz;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, 32'(data_out), 32'(exp_d));
        chk({tag, "_err"}, 32'(norm_err), 32'(exp_e));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drain_vld"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [3:0] held;
        logic [2:0] lzx;
        logic [3:0] nx;

        reset     = 1'b1;
        in_valid  = 1'b0;
        norm_in   = '0;
        lz_in     = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_err", 32'(norm_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of a shift discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        norm_in  = 4'b1000;
        lz_in    = 3'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mid_busy", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'd0);

        run_op("basic", 4'b1011, 3'd2, 4'b0010, 1'b0, 2);
        run_op("zero_shift", 4'b1100, 3'd0, 4'b1100, 1'b0, 0);
        run_op("all_zero", 4'b0000, 3'd4, 4'b0000, 1'b0, 4);
        run_op("sat_lz7", 4'b0000, 3'd7, 4'b0000, 1'b1, 4);
        run_op("msb_clear", 4'b0011, 3'd1, 4'b0001, 1'b1, 1);
        run_op("full_shift", 4'b1111, 3'd3, 4'b0001, 1'b0, 3);

        // Backpressure: result held, new requests refused.
        @(negedge clk);
        in_valid = 1'b1;
        norm_in  = 4'b1011;
        lz_in    = 3'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_valid", 32'(out_valid), 32'd1);
        held = data_out;
        chk("bp_data", 32'(held), 32'h5);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            norm_in  = 4'b1111;
            lz_in    = 3'd0;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp_hold_data", 32'(data_out), 32'h5);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_ghost", 32'(out_valid), 32'd0);

        // Round trip through a reference lzd for every operand.
        for (int x = 0; x < 16; x++) begin
            lzx = ref_lzd(4'(x));
            nx  = 4'(4'(x) << lzx);
            run_op($sformatf("rt_%0d", x), nx, lzx, 4'(x), 1'b0, int'(lzx));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
